// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - direction codes and key FSM states shared with the movement stage
package maze_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT,
    ST_WAIT_RELEASE
  } key_state_e;

  // Bit order of pressed matches the one-hot codes, so the winner maps directly.
  function automatic logic [3:0] priority_dir(input logic [3:0] pressed);
    logic [3:0] dir;
    dir = DIR_NONE;
    if (pressed[0])      dir = DIR_UP;
    else if (pressed[1]) dir = DIR_DOWN;
    else if (pressed[2]) dir = DIR_RIGHT;
    else if (pressed[3]) dir = DIR_LEFT;
    return dir;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - 2-FF synchroniser plus debounce counter for one active-low key
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic pressed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          pressed_q, pressed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          differs;

  always_comb begin
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    pressed_d = pressed_q;
    cnt_d     = '0;
    differs   = (~sync2_q) != pressed_q;
    // Any agreeing cycle restarts the count, so only an unbroken run flips the state.
    if (differs) begin
      if (cnt_q == CNT_LAST) begin
        pressed_d = ~pressed_q;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      pressed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pressed = pressed_q;

endmodule

// File: rtl/maze_direction_keys.sv
// rtl/maze_direction_keys.sv - debounced push-buttons to one-cycle direction pulses with auto-repeat
module maze_direction_keys
  import maze_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic       enable,
  output logic [3:0] player_direction,
  output logic       key_held
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [3:0]    pressed;
  key_state_e    state_q, state_d;
  logic [3:0]    active_q, active_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic [3:0]    dir_q, dir_d;
  logic          active_released;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clock  (clock),
      .reset  (reset),
      .key_n  (key_n[i]),
      .pressed(pressed[i])
    );
  end

  assign active_released = (pressed & active_q) == 4'b0000;

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    dir_d    = DIR_NONE;
    if (!enable) begin
      state_d = ST_WAIT_RELEASE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|pressed) begin
            dir_d    = priority_dir(pressed);
            active_d = priority_dir(pressed);
            cnt_d    = '0;
            state_d  = ST_DELAY;
          end
        end
        ST_DELAY: begin
          // Release wins over a coincident repeat pulse.
          if (active_released) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if (cnt_q == DELAY_LAST) begin
            dir_d   = active_q;
            cnt_d   = '0;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = cnt_q + RW'(1);
          end
        end
        ST_REPEAT: begin
          if (active_released) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if (cnt_q == PERIOD_LAST) begin
            dir_d = active_q;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + RW'(1);
          end
        end
        ST_WAIT_RELEASE: begin
          if (pressed == 4'b0000) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      active_q <= DIR_NONE;
      cnt_q    <= '0;
      dir_q    <= DIR_NONE;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
    end
  end

  assign player_direction = dir_q;
  assign key_held         = (state_q == ST_DELAY) || (state_q == ST_REPEAT);

endmodule

// File: doc/maze_direction_keys.md
# maze_direction_keys

Converts the four raw, active-low push-button inputs into clean one-cycle direction pulses for the player-movement stage. Each key is synchronised and debounced. The held key is priority-encoded to the one-hot direction code, and a typematic auto-repeat generates further pulses while the key stays held. The block sits directly upstream of the movement logic and drives its `player_direction` input. Every pulse is separated by at least one all-zero cycle, so each pulse is a distinct direction change.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before a debounced key changes state (1 ms at 50 MHz); must be ≥ 2.
- `REPEAT_DELAY`, default 25000000: cycles from the first pulse to the first auto-repeat pulse; must be ≥ 2.
- `REPEAT_PERIOD`, default 10000000: cycles between successive auto-repeat pulses; must be ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- `clock` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `key_n` input 4: raw buttons, active low, asynchronous. Bit 0 = UP, 1 = DOWN, 2 = RIGHT, 3 = LEFT.
- `enable` input 1: 0 blocks all pulses (driven low while the player is stopped or at the start).
- `player_direction` output 4: one-hot pulse; UP 4'b0001, DOWN 4'b0010, RIGHT 4'b0100, LEFT 4'b1000; otherwise 4'b0000.
- `key_held` output 1: high while the FSM is in DELAY or REPEAT.

## Operation
Input conditioning:
- Each `key_n` bit passes through a 2-FF synchroniser. The synchroniser flops reset to 1 (released).
- The debounced bit `pressed[i]` (1 = pressed) toggles on the edge at which the synchronised value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
- The counter clears on any cycle where the synchronised value equals `pressed[i]`. Width is $clog2(DEBOUNCE_CYCLES+1).

Direction selection:
- Priority is UP > DOWN > RIGHT > LEFT among the `pressed` bits.
- The winning key is latched as `active_dir` on entry to DELAY.

FSM states:
- IDLE: if `enable` is 1 and any key is pressed, emit a pulse for the priority key, latch it, clear the repeat counter, and go to DELAY.
- DELAY: the counter increments each cycle. When it reaches `REPEAT_DELAY`-1, emit a pulse, clear the counter, and go to REPEAT.
- REPEAT: the counter increments each cycle. When it reaches `REPEAT_PERIOD`-1, emit a pulse and clear the counter.
- WAIT_RELEASE: go to IDLE when all `pressed` bits are 0.

Exits and edge cases:
- From DELAY or REPEAT, release of `active_dir` has priority over a repeat pulse on the same cycle and sends the FSM to IDLE. Other keys still held then trigger from IDLE on the next cycle.
- Pressing another key while `active_dir` is held is ignored; there is no direction switch.
- `enable` = 0 in any state forces WAIT_RELEASE with output 0000 from the next edge. An `enable` rise while a key is held therefore produces no pulse until all keys are released.
- Reset with a key physically held: the debouncer restarts from "released", so a pulse follows after debounce latency.

## Timing
- Reset values: `player_direction` 0000, `key_held` 0, `pressed` 0000, state IDLE, all counters 0.
- `player_direction` is registered. Each pulse lasts exactly 1 cycle, followed by at least 1 cycle of 0000.
- Latency from the first edge sampling `key_n[i]`=0 to the pulse: `DEBOUNCE_CYCLES`+3 edges (2 synchroniser, `DEBOUNCE_CYCLES` debounce, 1 FSM/output).
- Pulse spacing while held: first-to-second = `REPEAT_DELAY`; thereafter `REPEAT_PERIOD`.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no change.

## Structure
- Shared package `maze_pkg`: direction constants DIR_UP/DOWN/RIGHT/LEFT/NONE (also used by the movement stage) and the FSM state enum.
- Sub-module `key_debouncer`: synchroniser plus debounce counter for one key, parameterised by `DEBOUNCE_CYCLES`, instantiated 4×.
- The top level holds the priority encoder, FSM, repeat counter and output register.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.
- Single tap: `key_n`=4'b1110 held 10 cycles after reset → one 0001 pulse exactly 7 edges after the press, then 0000 while held shorter than the repeat delay.
- Auto-repeat: hold RIGHT (`key_n`=4'b1011) 60 cycles → 0100 pulses at t=7, 27, 35, 43, 51, 59; `key_held`=1 from t=7 until release + debounce.
- Bounce rejection: LEFT toggled with 3-cycle low/high glitches for 30 cycles → no pulse; then held low → one 1000 pulse 7 edges after the stable press.
- Simultaneous keys: UP and LEFT pressed on the same edge → 0001 only. Release UP while LEFT is held → 1000 pulse on the edge after UP's debounced release.
- Enable gating: `enable`=0 while DOWN is held through the debounce → no pulse. `enable` rises with DOWN still held → no pulse. Release and re-press → 0010 after 7 edges.
- Reset mid-hold: assert `reset` during REPEAT with key held → output 0000 and `key_held`=0 the next cycle; after deassert, a pulse reappears 7 edges later.
